// File: rtl/cpu_operand_fetch_if.sv
// Bundle of every operand-fetch signal except clock and reset.
//   decode side : in_valid/in_ready handshake, in_rs1, in_rs2, in_rd, in_rd_write
//   bank side   : rf_addr_a/b out, rf_data_a/b combinational read data back
//   writeback   : wb_reg_write, wb_reg_dest, wb_data
//   execute side: out_valid/out_ready handshake, out_op_a/b, out_rd, out_rd_write
//   control     : flush in, sb_err (sticky scoreboard underflow) out
// The slave modport is the operand-fetch block; master is its environment.
interface cpu_operand_fetch_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_N  = 32
);
    localparam int unsigned REG_AW = $clog2(REG_N);

    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic              in_rd_write;
    logic [REG_AW-1:0] rf_addr_a;
    logic [REG_AW-1:0] rf_addr_b;
    logic [DATA_W-1:0] rf_data_a;
    logic [DATA_W-1:0] rf_data_b;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_reg_dest;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op_a;
    logic [DATA_W-1:0] out_op_b;
    logic [REG_AW-1:0] out_rd;
    logic              out_rd_write;
    logic              flush;
    logic              sb_err;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_write,
        input  rf_data_a, rf_data_b,
        input  wb_reg_write, wb_reg_dest, wb_data,
        input  out_ready, flush,
        output in_ready, rf_addr_a, rf_addr_b,
        output out_valid, out_op_a, out_op_b, out_rd, out_rd_write, sb_err
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_write,
        output rf_data_a, rf_data_b,
        output wb_reg_write, wb_reg_dest, wb_data,
        output out_ready, flush,
        input  in_ready, rf_addr_a, rf_addr_b,
        input  out_valid, out_op_a, out_op_b, out_rd, out_rd_write, sb_err
    );
endinterface

// File: rtl/cpu_operand_fetch.sv
// Operand fetch between decode and execute. Reads rs1/rs2 from the bank register file with
// same-cycle writeback bypass, tracks in-flight destination writes per register in a saturating-
// free counter scoreboard, stalls on RAW hazards or a full counter, and presents operands to
// execute through a single output register with valid/ready.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; clears outputs, counters and sb_err
//   bus    cpu_operand_fetch_if.slave (decode, bank, writeback, execute, flush, sb_err)
module cpu_operand_fetch #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_N  = 32,
    parameter int unsigned PEND_W = 2
) (
    input logic                 clock,
    input logic                 reset,
    cpu_operand_fetch_if.slave  bus
);
    localparam int unsigned REG_AW = $clog2(REG_N);
    localparam logic [PEND_W-1:0] CntMax = '1;
    localparam logic [PEND_W-1:0] CntOne = PEND_W'(1);

    logic [PEND_W-1:0] cnt_q [REG_N];
    logic [PEND_W-1:0] cnt_d [REG_N];
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              rd_write_q, rd_write_d;

    logic              wb_hit_a, wb_hit_b, wb_hit_rd;
    logic              hazard_a, hazard_b, full;
    logic              in_ready, accept, issue;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [REG_N-1:0]  inc_sel, dec_sel;

    assign wb_hit_a  = bus.wb_reg_write && (bus.wb_reg_dest == bus.in_rs1);
    assign wb_hit_b  = bus.wb_reg_write && (bus.wb_reg_dest == bus.in_rs2);
    assign wb_hit_rd = bus.wb_reg_write && (bus.wb_reg_dest == bus.in_rd);

    // Pending count net of a same-cycle writeback, or a held instruction not yet counted.
    assign hazard_a = (bus.in_rs1 != '0) &&
                      ((cnt_q[bus.in_rs1] > PEND_W'(wb_hit_a)) ||
                       (out_valid_q && rd_write_q && (rd_q == bus.in_rs1)));
    assign hazard_b = (bus.in_rs2 != '0) &&
                      ((cnt_q[bus.in_rs2] > PEND_W'(wb_hit_b)) ||
                       (out_valid_q && rd_write_q && (rd_q == bus.in_rs2)));

    assign full = bus.in_rd_write && (bus.in_rd != '0) &&
                  (cnt_q[bus.in_rd] == CntMax) && !wb_hit_rd;

    assign in_ready = (!out_valid_q || bus.out_ready) && !hazard_a && !hazard_b &&
                      !full && !bus.flush;
    assign accept   = bus.in_valid && in_ready;
    assign issue    = out_valid_q && bus.out_ready;

    assign sel_a = (bus.in_rs1 == '0) ? '0 : (wb_hit_a ? bus.wb_data : bus.rf_data_a);
    assign sel_b = (bus.in_rs2 == '0) ? '0 : (wb_hit_b ? bus.wb_data : bus.rf_data_b);

    always_comb begin
        out_valid_d = out_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rd_d        = rd_q;
        rd_write_d  = rd_write_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            op_a_d      = sel_a;
            op_b_d      = sel_b;
            rd_d        = bus.in_rd;
            rd_write_d  = bus.in_rd_write;
        end else if (issue) begin
            out_valid_d = 1'b0;
        end
    end

    // Counting at issue (not accept) means a flushed instruction never touches the scoreboard.
    always_comb begin
        inc_sel = '0;
        dec_sel = '0;
        if (issue && rd_write_q && (rd_q != '0)) begin
            inc_sel[rd_q] = 1'b1;
        end
        if (bus.wb_reg_write && (bus.wb_reg_dest != '0)) begin
            dec_sel[bus.wb_reg_dest] = 1'b1;
        end
    end

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < int'(REG_N); i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_sel[i] && !dec_sel[i]) begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end else if (dec_sel[i] && !inc_sel[i]) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CntOne;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rd_q        <= '0;
            rd_write_q  <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < int'(REG_N); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rd_q        <= rd_d;
            rd_write_q  <= rd_write_d;
            err_q       <= err_d;
            for (int i = 0; i < int'(REG_N); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.rf_addr_a    = bus.in_rs1;
    assign bus.rf_addr_b    = bus.in_rs2;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_op_a     = op_a_q;
    assign bus.out_op_b     = op_b_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_rd_write = rd_write_q;
    assign bus.sb_err       = err_q;
endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Directed scenarios followed by a randomized run, every cycle compared against a behavioural
// model built from integer counters, a held-instruction record and a bank array.
module tb_cpu_operand_fetch;
    localparam int DW  = 32;
    localparam int RN  = 32;
    localparam int PW  = 2;
    localparam int MAX = (1 << PW) - 1;

    logic clk;
    logic rst;
    logic [DW-1:0] rf_mem [RN];

    cpu_operand_fetch_if #(.DATA_W(DW), .REG_N(RN)) bus ();

    cpu_operand_fetch #(.DATA_W(DW), .REG_N(RN), .PEND_W(PW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Bench-side register bank with combinational read.
    assign bus.rf_data_a = rf_mem[bus.rf_addr_a];
    assign bus.rf_data_b = rf_mem[bus.rf_addr_b];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    bit          m_valid;
    logic [31:0] m_a, m_b;
    int          m_rd;
    bit          m_rdw;
    int          m_cnt [RN];
    bit          m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit wb_to(int r);
        return bus.wb_reg_write && (int'(bus.wb_reg_dest) == r);
    endfunction

    function automatic bit m_hazard(int r);
        int outstanding;
        if (r == 0) return 1'b0;
        outstanding = m_cnt[r] - (wb_to(r) ? 1 : 0);
        if (outstanding < 0) outstanding = 0;
        return (outstanding > 0) || (m_valid && m_rdw && m_rd == r);
    endfunction

    function automatic bit m_ready();
        int rd;
        bit full;
        rd   = int'(bus.in_rd);
        full = bus.in_rd_write && rd != 0 && m_cnt[rd] == MAX && !wb_to(rd);
        return (!m_valid || bus.out_ready) && !m_hazard(int'(bus.in_rs1)) &&
               !m_hazard(int'(bus.in_rs2)) && !full && !bus.flush;
    endfunction

    function automatic logic [31:0] m_operand(int r);
        if (r == 0) return 32'h0;
        if (wb_to(r)) return bus.wb_data;
        return rf_mem[r];
    endfunction

    task automatic m_clear();
        m_valid = 0; m_a = '0; m_b = '0; m_rd = 0; m_rdw = 0; m_err = 0;
        for (int i = 0; i < RN; i++) m_cnt[i] = 0;
    endtask

    // One clock: check all outputs against the model, then advance the model at the edge.
    task automatic cycle();
        bit rdy, iss, acc;
        int inc, dec, wdest;
        logic [31:0] wdata;
        bit wen;
        #1;
        rdy = m_ready();
        chk("in_ready", bus.in_ready, rdy);
        chk("rf_addr_a", bus.rf_addr_a, bus.in_rs1);
        chk("rf_addr_b", bus.rf_addr_b, bus.in_rs2);
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_op_a", bus.out_op_a, m_a);
        chk("out_op_b", bus.out_op_b, m_b);
        chk("out_rd", bus.out_rd, m_rd);
        chk("out_rd_write", bus.out_rd_write, m_rdw);
        chk("sb_err", bus.sb_err, m_err);
        wen   = bus.wb_reg_write && bus.wb_reg_dest != '0;
        wdest = int'(bus.wb_reg_dest);
        wdata = bus.wb_data;
        @(posedge clk);
        if (rst) begin
            m_clear();
        end else begin
            iss = m_valid && bus.out_ready;
            acc = bus.in_valid && rdy;
            inc = (iss && m_rdw && m_rd != 0) ? m_rd : -1;
            dec = wen ? wdest : -1;
            if (inc != dec) begin
                if (inc >= 0) m_cnt[inc]++;
                if (dec >= 0) begin
                    if (m_cnt[dec] == 0) m_err = 1;
                    else m_cnt[dec]--;
                end
            end
            if (bus.flush) begin
                m_valid = 0;
            end else if (acc) begin
                m_valid = 1;
                m_a     = m_operand(int'(bus.in_rs1));
                m_b     = m_operand(int'(bus.in_rs2));
                m_rd    = int'(bus.in_rd);
                m_rdw   = bus.in_rd_write;
            end else if (iss) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        if (wen) rf_mem[wdest] = wdata;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
        bus.in_rd_write = 0; bus.wb_reg_write = 0; bus.wb_reg_dest = '0; bus.wb_data = '0;
        bus.out_ready = 1; bus.flush = 0;
    endtask

    task automatic instr(input int rs1, input int rs2, input int rd, input bit rdw);
        bus.in_valid = 1; bus.in_rs1 = 5'(rs1); bus.in_rs2 = 5'(rs2);
        bus.in_rd = 5'(rd); bus.in_rd_write = rdw;
    endtask

    task automatic wb(input int dest, input logic [31:0] data);
        bus.wb_reg_write = 1; bus.wb_reg_dest = 5'(dest); bus.wb_data = data;
    endtask

    initial begin
        for (int i = 0; i < RN; i++) rf_mem[i] = $urandom;
        rf_mem[1] = 32'd4;
        rf_mem[2] = 32'd9;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        m_clear();
        @(negedge clk);
        rst = 0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_op_a", bus.out_op_a, 0);
        chk("rst_op_b", bus.out_op_b, 0);
        chk("rst_sb_err", bus.sb_err, 0);

        // T1: plain read.
        instr(1, 2, 0, 0); cycle();
        bus.in_valid = 0;
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_op_a", bus.out_op_a, 32'd4);
        chk("t1_op_b", bus.out_op_b, 32'd9);
        cycle();

        // T2: bypass; first put one write to r1 in flight so the writeback is legal.
        instr(0, 0, 1, 1); cycle();
        bus.in_valid = 0; cycle();
        instr(1, 0, 0, 0); wb(1, 32'd1); cycle();
        idle_inputs();
        chk("t2_op_a", bus.out_op_a, 32'd1);
        chk("t2_sb_err", bus.sb_err, 0);
        cycle();

        // T3: RAW stall until writeback of r3.
        instr(0, 0, 3, 1); cycle();
        bus.in_valid = 0; cycle();
        instr(3, 0, 0, 0);
        #1 chk("t3_stall0", bus.in_ready, 0);
        cycle();
        #1 chk("t3_stall1", bus.in_ready, 0);
        cycle();
        wb(3, 32'h33);
        #1 chk("t3_release", bus.in_ready, 1);
        cycle();
        idle_inputs();
        chk("t3_op_a", bus.out_op_a, 32'h33);
        cycle();

        // T4: three writes to r5 in flight fill the counter.
        for (int k = 0; k < 3; k++) begin
            instr(0, 0, 5, 1); cycle();
            bus.in_valid = 0; cycle();
        end
        instr(0, 0, 5, 1);
        #1 chk("t4_full", bus.in_ready, 0);
        cycle();
        wb(5, 32'h55);
        #1 chk("t4_drain", bus.in_ready, 1);
        cycle();
        idle_inputs();
        cycle();
        for (int k = 0; k < 3; k++) begin
            wb(5, $urandom); cycle();
        end
        idle_inputs();

        // T5: flush a held write to r6.
        instr(0, 0, 6, 1); bus.out_ready = 0; cycle();
        bus.in_valid = 0; bus.flush = 1;
        #1 chk("t5_flush_ready", bus.in_ready, 0);
        cycle();
        bus.flush = 0;
        chk("t5_valid", bus.out_valid, 0);
        instr(6, 0, 0, 0); bus.out_ready = 1;
        #1 chk("t5_reader", bus.in_ready, 1);
        cycle();
        idle_inputs(); cycle();

        // T6: r0 never bypassed; writeback to idle register flags sb_err.
        instr(0, 0, 0, 0); wb(0, 32'hFFFF); cycle();
        idle_inputs();
        chk("t6_op_a", bus.out_op_a, 0);
        chk("t6_no_err", bus.sb_err, 0);
        wb(7, 32'h1); cycle();
        idle_inputs();
        chk("t6_sb_err", bus.sb_err, 1);
        cycle();

        // Reset in the middle of a held instruction.
        instr(1, 2, 2, 1); bus.out_ready = 0; cycle();
        rst = 1; wb(4, 32'h7); cycle();
        rst = 0; idle_inputs();
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_err", bus.sb_err, 0);
        cycle();

        // Randomized run.
        for (int n = 0; n < 1500; n++) begin
            int r;
            rst = ($urandom_range(0, 199) == 0);
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_rs1      = 5'($urandom_range(0, 7));
            bus.in_rs2      = 5'($urandom_range(0, 7));
            bus.in_rd       = 5'($urandom_range(0, 7));
            bus.in_rd_write = $urandom_range(0, 1) == 1;
            // Decode never lets a held write plus the counter exceed the counter range.
            if (m_valid && m_rdw && m_rd == int'(bus.in_rd)) bus.in_rd_write = 0;
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            bus.flush       = ($urandom_range(0, 19) == 0);
            r = $urandom_range(1, 7);
            bus.wb_data = $urandom;
            if (m_cnt[r] > 0 && $urandom_range(0, 1) == 1) begin
                bus.wb_reg_write = 1; bus.wb_reg_dest = 5'(r);
            end else begin
                bus.wb_reg_write = ($urandom_range(0, 49) == 0);
                bus.wb_reg_dest  = 5'($urandom_range(0, 7));
            end
            cycle();
        end
        rst = 0;
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
